// File: rtl/disp_pkg.sv
// Shared constants for the time display stage: segment codes, mode/field
// encodings and digit positions.
package disp_pkg;

   localparam int NUM_DIGITS = 6;

   // Active-low segment patterns, bit order g..a.
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [1:0] MODE_SET = 2'b10;

   // Only the low bit of the field select matters (00/10 vs 01/11).
   localparam logic FLD_MIN  = 1'b0;
   localparam logic FLD_HOUR = 1'b1;

   localparam logic [2:0] DIG_SEC_LO  = 3'd0;
   localparam logic [2:0] DIG_SEC_HI  = 3'd1;
   localparam logic [2:0] DIG_MIN_LO  = 3'd2;
   localparam logic [2:0] DIG_MIN_HI  = 3'd3;
   localparam logic [2:0] DIG_HOUR_LO = 3'd4;
   localparam logic [2:0] DIG_HOUR_HI = 3'd5;

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 are blank.
module bcd7seg
   import disp_pkg::*;
(
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_BLANK;
      case (i_bcd)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/scan_disp.sv
// Six-digit multiplexed 7-segment driver with set-mode field blinking.
// Optional macro LEAD_ZERO_BLANK_EN suppresses a leading zero in the hours.
module scan_disp
   import disp_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 12500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] c,
   input  logic [3:0] d,
   input  logic [3:0] e,
   input  logic [3:0] f,
   input  logic [1:0] mk,
   input  logic [1:0] k1,
   output logic [5:0] sel,
   output logic [7:0] seg
);

   localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
   localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);

   logic [SCAN_W-1:0]  r_scan_cnt;
   logic [BLINK_W-1:0] r_blink_cnt;
   logic [2:0]         r_idx;
   logic               r_phase;
   logic [5:0]         r_sel;
   logic [7:0]         r_seg;

   logic [3:0] w_digit;
   logic [6:0] w_dec;
   logic       w_blank;
   logic       w_dp_n;
   logic [5:0] w_sel;

   always_comb begin
      w_digit = a;
      case (r_idx)
         DIG_SEC_LO:  w_digit = a;
         DIG_SEC_HI:  w_digit = b;
         DIG_MIN_LO:  w_digit = c;
         DIG_MIN_HI:  w_digit = d;
         DIG_HOUR_LO: w_digit = e;
         DIG_HOUR_HI: w_digit = f;
         default:     w_digit = a;
      endcase
   end

   bcd7seg u_dec (
      .i_bcd (w_digit),
      .o_seg (w_dec)
   );

   // Blink only the field under adjustment, during the dark half of the blink period.
   always_comb begin
      w_blank = 1'b0;
      if (mk == MODE_SET && r_phase) begin
         if (k1[0] == FLD_HOUR)
            w_blank = (r_idx == DIG_HOUR_LO) || (r_idx == DIG_HOUR_HI);
         else
            w_blank = (r_idx == DIG_MIN_LO) || (r_idx == DIG_MIN_HI);
      end
`ifdef LEAD_ZERO_BLANK_EN
      if (r_idx == DIG_HOUR_HI && f == 4'd0)
         w_blank = 1'b1;
`endif
   end

   assign w_dp_n = !((r_idx == DIG_MIN_LO) || (r_idx == DIG_HOUR_LO));
   assign w_sel  = ~(6'b000001 << r_idx);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan_cnt  <= '0;
         r_idx       <= DIG_SEC_LO;
         r_blink_cnt <= '0;
         r_phase     <= 1'b0;
         r_sel       <= 6'h3F;
         r_seg       <= 8'hFF;
      end else begin
         if (r_scan_cnt == SCAN_MAX) begin
            r_scan_cnt <= '0;
            r_idx      <= (r_idx == DIG_HOUR_HI) ? DIG_SEC_LO : r_idx + 3'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end

         if (r_blink_cnt == BLINK_MAX) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
         end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
         end

         r_sel <= w_sel;
         r_seg <= {w_dp_n, (w_blank ? SEG_BLANK : w_dec)};
      end
   end

   assign sel = r_sel;
   assign seg = r_seg;

endmodule

// File: tb/tb_scan_disp.sv
// Bench for scan_disp: directed phases plus random digits, checked against a
// time-based model (digit and blink phase derived from cycles since reset).
module tb_scan_disp;

   localparam int SD = 4;
   localparam int BD = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] a, b, c, d, e, f;
   logic [1:0] mk, k1;
   logic [5:0] sel;
   logic [7:0] seg;

   int checks = 0;
   int errors = 0;
   int t = 0;   // clock edges since reset was last released

   always #5 clk = ~clk;

   scan_disp #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .clk (clk), .rst (rst),
      .a (a), .b (b), .c (c), .d (d), .e (e), .f (f),
      .mk (mk), .k1 (k1),
      .sel (sel), .seg (seg)
   );

   function automatic logic [6:0] seg_code(input logic [3:0] v);
      logic [7:0] tbl [16];
      logic [7:0] x;
      tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      x = tbl[v];
      return x[6:0];
   endfunction

   // Expected outputs after edge number t, from elapsed time alone.
   task automatic model(output logic [5:0] es, output logic [7:0] eg);
      int idx, ph;
      logic [3:0] dig [6];
      logic [6:0] body;
      logic blank;
      if (t == 0) begin
         es = 6'h3F;
         eg = 8'hFF;
         return;
      end
      idx = ((t - 1) / SD) % 6;
      ph  = ((t - 1) / BD) % 2;
      dig = '{a, b, c, d, e, f};
      blank = 1'b0;
      if (mk == 2'b10 && ph == 1)
         blank = k1[0] ? (idx >= 4) : (idx == 2 || idx == 3);
`ifdef LEAD_ZERO_BLANK_EN
      if (idx == 5 && f == 4'd0) blank = 1'b1;
`endif
      body = blank ? 7'h7F : seg_code(dig[idx]);
      es = 6'h3F;
      es[idx] = 1'b0;
      eg = {(idx == 2 || idx == 4) ? 1'b0 : 1'b1, body};
   endtask

   task automatic step();
      logic [5:0] es;
      logic [7:0] eg;
      @(posedge clk);
      if (rst) t = 0;
      else t++;
      #1;
      model(es, eg);
      checks++;
      assert (sel === es) else begin
         errors++;
         $error("FAIL sel t=%0d observed=%h expected=%h", t, sel, es);
      end
      checks++;
      assert (seg === eg) else begin
         errors++;
         $error("FAIL seg t=%0d observed=%h expected=%h", t, seg, eg);
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int guard;
      {a, b, c, d, e, f} = {4'd9, 4'd5, 4'd9, 4'd5, 4'd3, 4'd2};
      mk = 2'b00;
      k1 = 2'b00;

      // Reset held three cycles.
      rst = 1'b1;
      run(3);

      // Release: first digit enable one cycle later, then a normal scan.
      rst = 1'b0;
      step();
      checks++;
      assert (sel === 6'h3E && seg === 8'h90) else begin
         errors++;
         $error("FAIL first_digit observed=%h/%h expected=3e/90", sel, seg);
      end
      run(47);

      // Minutes field blinking, then hours field, then leave set mode mid-phase.
      mk = 2'b10; k1 = 2'b00; run(64);
      k1 = 2'b10; run(16);
      k1 = 2'b01; run(40);
      k1 = 2'b11; run(10);
      mk = 2'b00; run(20);
      mk = 2'b01; run(16);
      mk = 2'b11; run(16);

      // Out-of-range BCD on the minutes-high digit.
      mk = 2'b00; d = 4'hC; run(24);
      d = 4'd5;

      // Reset while the scan sits on index 4.
      guard = 0;
      while (((t / SD) % 6) != 4 && guard < 100) begin
         step();
         guard++;
      end
      checks++;
      assert (guard < 100) else begin
         errors++;
         $error("FAIL reach_idx4 observed=%0d expected<100", guard);
      end
      step();
      rst = 1'b1; step();
      rst = 1'b0; run(30);

      // Hours-high zero.
      f = 4'd0; run(24);

      // Random digits and modes.
      for (int i = 0; i < 800; i++) begin
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         c = 4'($urandom_range(0, 15));
         d = 4'($urandom_range(0, 15));
         e = 4'($urandom_range(0, 15));
         f = 4'($urandom_range(0, 15));
         if (i % 8 == 0) begin
            mk = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(0, 3));
            k1 = 2'($urandom_range(0, 3));
         end
         if (i == 400) rst = 1'b1;
         if (i == 401) rst = 1'b0;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
